serial_source: RTL and testbench
================================

# serial_source

Traffic-generating transmitter for the serial link; it is the far end of `serial_sink`. It generates sequence-numbered flits at a programmable rate and buffers them in a small FIFO. It serializes each flit onto a one-wire link, honouring the receiver's `channel_busy` back-pressure, and reports per-window injection throughput and dropped-flit counts for NoC load experiments.

## Interface
- `SIZE`, default 8: flit width in bits; must be ≥ 2.
- `INJ_PERIOD`, default 4: cycles between generation attempts; must be ≥ 1.
- `FIFO_DEPTH`, default 4: flit buffer entries; power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  generation enable; transmission of already-buffered flits continues when low.
- `channel_busy`  in  1  receiver back-pressure; a new frame must not start while high.
- `serial_out`  out  1  registered serial line.
- `tx_active`  out  1  high while a frame is on the line (START or DATA state).
- `througput`  out  26  flits whose start bit was issued in the last completed 1024-cycle window.
- `dropped`  out  16  saturating count of flits dropped because the FIFO was full.

## Operation
- Frame format:
  - idle line = 0;
  - one start bit = 1;
  - then `SIZE` data bits, LSB first;
  - then one guard cycle at 0.
  - Frame length is `SIZE`+2 cycles, start to end of guard.
- Generator:
  - A period counter counts 0..`INJ_PERIOD`-1 and runs only while `enable`=1.
  - A generation attempt occurs on the cycle the counter is `INJ_PERIOD`-1 and `enable`=1; the counter then wraps to 0.
  - Deasserting `enable` holds the counter at its current value.
  - Payload is a `SIZE`-bit sequence register. It resets to 1, increments modulo 2^`SIZE` after every attempt (accepted or dropped), and wraps from all-ones to 0.
  - If the FIFO is full at the attempt, the flit is dropped and `dropped` increments, saturating at 0xFFFF. Otherwise the flit is pushed.
- FIFO: synchronous, first-word-fall-through, `FIFO_DEPTH` entries, wrapping pointers. Push and pop in the same cycle while full is allowed: the pop frees the slot, so the push is accepted.
- TX state machine:
  - IDLE: `serial_out`=0. If the FIFO is non-empty and `channel_busy`=0, pop the head into the shift register, drive the start bit, and go to START.
  - START: `serial_out`=1 for one cycle, then go to DATA with bit index 0.
  - DATA: `serial_out` = shift[0]; shift right each cycle. After bit `SIZE`-1, go to GUARD.
  - GUARD: `serial_out`=0 for one cycle, then IDLE.
  - `channel_busy` is sampled only in IDLE. Assertion mid-frame does not abort the frame.
- Throughput: a 10-bit sampler counts every cycle.
  - On sampler = 1023: `througput` ← running + (pop this cycle), and running ← 0.
  - Otherwise: running ← running + (pop this cycle).
  - The sampler wraps to 0 after 1023.
- Reset values: all outputs 0, state IDLE, FIFO empty, sequence = 1, period counter 0, sampler 0. Reset mid-frame truncates the frame and forces `serial_out`=0 immediately (asynchronously); the truncated flit is lost.

## Timing
- Generation attempt at edge N: the flit is visible at the FIFO head after edge N.
- Fastest path from an attempt at edge N, with FIFO previously empty and `channel_busy`=0:
  - pop at edge N+1;
  - `serial_out`=1 (start bit) during the cycle after N+1;
  - data bit k during the cycle after edge N+2+k.
- Back-to-back frames: the next pop occurs in the IDLE cycle after GUARD. Minimum frame spacing is `SIZE`+3 cycles, start bit to start bit.
- Sustained throughput without drops requires `INJ_PERIOD` ≥ `SIZE`+3; otherwise the FIFO fills and drops accrue.
- `channel_busy` has a one-cycle effect: it is checked combinationally in IDLE against the registered state.

## Test plan
- Reset release, `enable`=1, `INJ_PERIOD`=16, `SIZE`=8, `channel_busy`=0 -> first frame on `serial_out` is 1,1,0,0,0,0,0,0,0,0 (start, then 0x01 LSB first, then guard), followed by 0x02 and 0x03 in subsequent frames.
- Hold `channel_busy`=1 for 100 cycles with `INJ_PERIOD`=4 -> no start bit appears. The FIFO fills with 0x01..0x04, and `dropped` reaches 21 by cycle 100. After release, frames carry 0x01..0x04 in order, then the next generated value.
- Assert `channel_busy` during DATA of a frame -> the frame completes unchanged; the next frame starts only after `channel_busy` is low in IDLE.
- `INJ_PERIOD`=11, `SIZE`=8, steady state -> `througput` = 93 in every full window after the first (1024/11 rounded down; exact per window ±1), and `dropped` stays 0.
- Assert reset during DATA bit 3 -> `serial_out`=0 immediately and all counters 0. After release, the first frame carries 0x01.
- Sequence wrap: run 256 attempts with no drops -> frame 256 carries 0x00 and frame 257 carries 0x01.

Source files
------------

// File: rtl/serial_source.sv
// serial_source: rate-programmable flit generator with FIFO buffering and a
// one-wire framed serializer (start=1, SIZE data bits LSB first, guard=0).
// Also reports pops per 1024-cycle window and a saturating drop count.
module serial_source #(
   parameter int unsigned SIZE       = 8,
   parameter int unsigned INJ_PERIOD = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        channel_busy,
   output logic        serial_out,
   output logic        tx_active,
   output logic [25:0] througput,
   output logic [15:0] dropped
);

   localparam int unsigned PW = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned IW = $clog2(SIZE);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = 26;
   localparam int unsigned DW = 16;
   localparam int unsigned SW = 10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_GUARD = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       per_cnt_q;
   logic [SIZE-1:0]     seq_q;
   logic [SIZE-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q;
   logic [SIZE-1:0]     shift_q;
   logic [IW-1:0]       bit_idx_q;
   logic [SW-1:0]       sampler_q;
   logic [TW-1:0]       running_q;

   logic                attempt_c, fifo_full_c, fifo_empty_c;
   logic                push_c, pop_c, drop_c, last_bit_c;
   logic                serial_d, tx_active_d;

   assign attempt_c    = enable && (per_cnt_q == PW'(INJ_PERIOD - 1));
   assign fifo_full_c  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty_c = (count_q == '0);
   assign last_bit_c   = (bit_idx_q == IW'(SIZE - 1));
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_c       = attempt_c && (!fifo_full_c || pop_c);
   assign drop_c       = attempt_c && fifo_full_c && !pop_c;

   // Period counter and sequence register; both freeze while enable is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         per_cnt_q <= '0;
         seq_q     <= SIZE'(1);
      end else begin
         if (enable) begin
            if (attempt_c) per_cnt_q <= '0;
            else           per_cnt_q <= per_cnt_q + PW'(1);
         end
         if (attempt_c) seq_q <= seq_q + SIZE'(1);
      end
   end

   // FIFO storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr_q] <= seq_q;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // TX state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // TX next-state logic; channel_busy only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!fifo_empty_c && !channel_busy) state_d = S_START;
         S_START: state_d = S_DATA;
         S_DATA:  if (last_bit_c) state_d = S_GUARD;
         S_GUARD: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // TX output decode: pop strobe and next values of the registered line.
   always_comb begin
      pop_c       = 1'b0;
      serial_d    = 1'b0;
      tx_active_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty_c && !channel_busy) begin
               pop_c       = 1'b1;
               serial_d    = 1'b1;
               tx_active_d = 1'b1;
            end
         end
         S_START: begin
            serial_d    = shift_q[0];
            tx_active_d = 1'b1;
         end
         S_DATA: begin
            if (!last_bit_c) begin
               serial_d    = shift_q[1];
               tx_active_d = 1'b1;
            end
         end
         default: begin
            serial_d    = 1'b0;
            tx_active_d = 1'b0;
         end
      endcase
   end

   // Shift register, bit index and registered line outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q    <= '0;
         bit_idx_q  <= '0;
         serial_out <= 1'b0;
         tx_active  <= 1'b0;
      end else begin
         serial_out <= serial_d;
         tx_active  <= tx_active_d;
         if (pop_c) shift_q <= mem[rd_ptr_q];
         if (state_q == S_START) begin
            bit_idx_q <= '0;
         end else if (state_q == S_DATA && !last_bit_c) begin
            bit_idx_q <= bit_idx_q + IW'(1);
            shift_q   <= shift_q >> 1;
         end
      end
   end

   // Windowed throughput: pops counted over each 1024-cycle sampler period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sampler_q <= '0;
         running_q <= '0;
         througput <= '0;
      end else begin
         sampler_q <= sampler_q + SW'(1);
         if (sampler_q == SW'(1023)) begin
            througput <= running_q + TW'(pop_c);
            running_q <= '0;
         end else begin
            running_q <= running_q + TW'(pop_c);
         end
      end
   end

   // Saturating drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              dropped <= '0;
      else if (drop_c && dropped != DW'(16'hFFFF)) dropped <= dropped + DW'(1);
   end

endmodule

// File: tb/tb_serial_source.sv
// Directed bench for serial_source: two instances (INJ_PERIOD 4 and 11)
// sharing one clock, checked against hand-computed frame contents and timing.
module tb_serial_source;

   logic        clk = 1'b0;
   logic        reset_a, enable_a, busy_a, so_a, txa_a;
   logic        reset_b, enable_b, busy_b, so_b, txa_b;
   logic [25:0] thr_a, thr_b;
   logic [15:0] drp_a, drp_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // Free-running edge counter used to measure latencies.
   always @(posedge clk) cyc <= cyc + 1;

   serial_source #(.SIZE(8), .INJ_PERIOD(4), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .reset(reset_a), .enable(enable_a), .channel_busy(busy_a),
      .serial_out(so_a), .tx_active(txa_a), .througput(thr_a), .dropped(drp_a)
   );

   serial_source #(.SIZE(8), .INJ_PERIOD(11), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .reset(reset_b), .enable(enable_b), .channel_busy(busy_b),
      .serial_out(so_b), .tx_active(txa_b), .througput(thr_b), .dropped(drp_b)
   );

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic line_of(input bit sel);
      return sel ? so_b : so_a;
   endfunction

   // Wait (bounded) for a start bit, then read 8 data bits and the guard bit.
   task automatic capture(input bit sel, input logic [7:0] exp, input string tag,
                          output int start_cyc);
      bit         found = 1'b0;
      logic [7:0] d = '0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (line_of(sel)) found = 1'b1;
      end
      start_cyc = cyc;
      check({tag, "_start"}, 32'(found), 32'd1);
      if (found) begin
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d[k] = line_of(sel);
         end
         check(tag, 32'(d), 32'(exp));
         @(negedge clk);
         check({tag, "_guard"}, 32'(line_of(sel)), 32'd0);
      end
   endtask

   initial begin
      int         t0;
      int         st;
      int         hits;
      bit         found;
      logic [7:0] d;

      reset_a = 1'b1; enable_a = 1'b0; busy_a = 1'b0;
      reset_b = 1'b1; enable_b = 1'b0; busy_b = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_so_a",  32'(so_a),  32'd0);
      check("rst_tx_a",  32'(txa_a), 32'd0);
      check("rst_so_b",  32'(so_b),  32'd0);
      check("rst_tx_b",  32'(txa_b), 32'd0);
      check("rst_thr_b", 32'(thr_b), 32'd0);
      check("rst_drp_b", 32'(drp_b), 32'd0);

      // Instance B: first frames, latency from reset release.
      reset_b = 1'b0; enable_b = 1'b1; t0 = cyc;
      capture(1'b1, 8'h01, "b_f1", st);
      check("b_f1_latency", 32'(st - t0), 32'd12);
      capture(1'b1, 8'h02, "b_f2", st);
      capture(1'b1, 8'h03, "b_f3", st);

      // Frame 4: raise busy mid-DATA; frame must finish unchanged.
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (so_b) found = 1'b1;
      end
      check("b_f4_start", 32'(found), 32'd1);
      d = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         d[k] = so_b;
         if (k == 2) busy_b = 1'b1;
      end
      check("b_f4_midbusy", 32'(d), 32'h04);
      @(negedge clk);
      check("b_f4_guard", 32'(so_b), 32'd0);
      hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (so_b || txa_b) hits++;
      end
      check("b_busy_hold", 32'(hits), 32'd0);
      busy_b = 1'b0;
      @(negedge clk);
      check("b_release_start", 32'(so_b), 32'd1);
      d = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         d[k] = so_b;
      end
      check("b_f5", 32'(d), 32'h05);

      // Remaining frames through the sequence wrap (256 -> 0x00, 257 -> 0x01).
      for (int n = 6; n <= 257; n++) begin
         capture(1'b1, 8'(n), $sformatf("b_f%0d", n), st);
         if (n == 200)
            check("b_thr_win2", 32'(thr_b >= 26'd92 && thr_b <= 26'd94), 32'd1);
      end
      while (cyc - t0 < 3075) @(negedge clk);
      check("b_thr_win3", 32'(thr_b >= 26'd92 && thr_b <= 26'd94), 32'd1);
      check("b_no_drops", 32'(drp_b), 32'd0);
      enable_b = 1'b0;

      // Instance A: busy held 100 cycles, FIFO fills, drops accrue.
      reset_a = 1'b0; enable_a = 1'b1; busy_a = 1'b1; t0 = cyc;
      hits = 0;
      repeat (100) begin
         @(negedge clk);
         if (so_a || txa_a) hits++;
      end
      check("a_busy_no_start", 32'(hits), 32'd0);
      check("a_dropped_21", 32'(drp_a), 32'd21);
      busy_a = 1'b0;
      capture(1'b0, 8'h01, "a_f1", st);
      check("a_f1_latency", 32'(st - t0), 32'd101);
      capture(1'b0, 8'h02, "a_f2", st);
      capture(1'b0, 8'h03, "a_f3", st);
      capture(1'b0, 8'h04, "a_f4", st);
      capture(1'b0, 8'h1A, "a_f5", st);

      // Frame 6 (0x1C): reset during data bit 3.
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (so_a) found = 1'b1;
      end
      check("a_f6_start", 32'(found), 32'd1);
      d = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         d[k] = so_a;
      end
      check("a_f6_low_nibble", 32'(d[3:0]), 32'hC);
      reset_a = 1'b1;
      #1;
      check("a_rst_so",  32'(so_a),  32'd0);
      check("a_rst_tx",  32'(txa_a), 32'd0);
      check("a_rst_drp", 32'(drp_a), 32'd0);
      check("a_rst_thr", 32'(thr_a), 32'd0);
      @(negedge clk);
      @(negedge clk);

      // Release with enable low for 10 cycles; counter must hold.
      enable_a = 1'b0; reset_a = 1'b0; t0 = cyc;
      repeat (10) @(negedge clk);
      enable_a = 1'b1;
      capture(1'b0, 8'h01, "a_post_rst", st);
      check("a_post_rst_latency", 32'(st - t0), 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
